// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage constants: bubble encoding, PC step and fetch FSM state encoding.
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_INST  = 32'h0000_0033;  // add x0,x0,x0; IF/ID uses the same word on flush
    localparam int          INST_STEP = 4;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory request/response and IF/ID output.
interface if_fetch_stage_if #(
    parameter int DATA_LEN = 32
);
    logic                Stall_i;
    logic                Branch_i;
    logic [DATA_LEN-1:0] Target_i;
    logic                imem_req_o;
    logic [DATA_LEN-1:0] imem_addr_o;
    logic                imem_rvalid_i;
    logic [DATA_LEN-1:0] imem_rdata_i;
    logic [DATA_LEN-1:0] PC_o;
    logic [DATA_LEN-1:0] inst_o;
    logic                valid_o;

    modport fetch (
        input  Stall_i, Branch_i, Target_i, imem_rvalid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, PC_o, inst_o, valid_o
    );

    modport env (
        output Stall_i, Branch_i, Target_i, imem_rvalid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, PC_o, inst_o, valid_o
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Single-outstanding instruction fetch feeding IF/ID; response is presented combinationally the cycle it
// returns (2 cycles/instr at latency 1), parked in a hold buffer while Stall_i is high; Branch_i wins over Stall_i.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                 DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    if_fetch_stage_if.fetch bus
);

    fetch_state_e        state_q, state_d;
    logic [DATA_LEN-1:0] pc_q, pc_d;
    logic [DATA_LEN-1:0] hold_q, hold_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ISSUE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        hold_d          = hold_q;
        bus.imem_req_o  = 1'b0;
        bus.imem_addr_o = pc_q;
        bus.PC_o        = pc_q;
        bus.inst_o      = NOP_INST;
        bus.valid_o     = 1'b0;

        unique case (state_q)
            ST_ISSUE: begin
                bus.imem_req_o = 1'b1;
                // The request has already left, so a redirect must still swallow its response.
                state_d = bus.Branch_i ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rvalid_i) begin
                    state_d = ST_ISSUE;
                    if (!bus.Branch_i) begin
                        bus.valid_o = 1'b1;
                        bus.inst_o  = bus.imem_rdata_i;
                        if (bus.Stall_i) begin
                            hold_d  = bus.imem_rdata_i;
                            state_d = ST_HOLD;
                        end else begin
                            pc_d = pc_q + DATA_LEN'(INST_STEP);
                        end
                    end
                end else if (bus.Branch_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (bus.Branch_i) begin
                    state_d = ST_ISSUE;
                end else begin
                    bus.valid_o = 1'b1;
                    bus.inst_o  = hold_q;
                    if (!bus.Stall_i) begin
                        pc_d    = pc_q + DATA_LEN'(INST_STEP);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.imem_rvalid_i) state_d = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase

        if (bus.Branch_i) pc_d = bus.Target_i;

        if (rst_i) begin
            bus.imem_req_o = 1'b0;
            bus.valid_o    = 1'b0;
            bus.inst_o     = NOP_INST;
        end
    end

    a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.imem_rvalid_i && (state_q == ST_ISSUE || state_q == ST_HOLD)));

endmodule
